// File: rtl/kbd_scancode_fifo.sv
// kbd_scancode_fifo: MMIO scancode FIFO between the PS/2 keyboard driver and
// the MCU IOBUS, with a level interrupt while unread codes are queued.
// Ports:
//   CLK, RESET_N       system clock, synchronous active-low reset
//   SCAN_VALID         driver strobe; rising edge pushes SCANCODE
//   SCANCODE[7:0]      scancode, stable while SCAN_VALID is high
//   IOBUS_ADDR[31:0]   MCU address (DATA_AD = pop, STAT_AD = status/control)
//   IOBUS_RD/WR        1-cycle read / write strobes
//   IOBUS_OUT[31:0]    MCU write data (control bits 2:0)
//   IOBUS_IN[31:0]     combinational read data
//   INTR               registered level interrupt
module kbd_scancode_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] DATA_AD = 32'h1100_0100,
  parameter logic [31:0] STAT_AD = 32'h1100_0104
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        SCAN_VALID,
  input  logic [7:0]  SCANCODE,
  input  logic [31:0] IOBUS_ADDR,
  input  logic        IOBUS_RD,
  input  logic        IOBUS_WR,
  input  logic [31:0] IOBUS_OUT,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_ie, r_intr, r_sv_q;

  logic [AW-1:0] w_wr_ptr_nx, w_rd_ptr_nx;
  logic [CW-1:0] w_count_nx;
  logic          w_ovf_nx, w_ie_nx;
  logic          w_empty, w_full;
  logic          w_push_req, w_push, w_pop, w_ctrl_wr, w_flush, w_ovf_set;
  logic [7:0]    w_head;
  logic          w_unused_wdata;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_push_req = SCAN_VALID & ~r_sv_q;
  assign w_pop      = IOBUS_RD & (IOBUS_ADDR == DATA_AD) & ~w_empty;
  assign w_ctrl_wr  = IOBUS_WR & (IOBUS_ADDR == STAT_AD);
  assign w_flush    = w_ctrl_wr & IOBUS_OUT[2];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_unused_wdata = ^IOBUS_OUT[31:3];

  // Next-state for pointers, count and control bits; flush overrides push/pop.
  always_comb begin
    w_wr_ptr_nx = r_wr_ptr;
    w_rd_ptr_nx = r_rd_ptr;
    w_count_nx  = r_count;
    w_ovf_nx    = r_ovf;
    w_ie_nx     = r_ie;
    if (w_push) w_wr_ptr_nx = r_wr_ptr + AW'(1);
    if (w_pop)  w_rd_ptr_nx = r_rd_ptr + AW'(1);
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CW'(1);
      2'b01:   w_count_nx = r_count - CW'(1);
      default: w_count_nx = r_count;
    endcase
    if (w_flush) begin
      w_wr_ptr_nx = '0;
      w_rd_ptr_nx = '0;
      w_count_nx  = '0;
    end
    if (w_ctrl_wr) begin
      w_ie_nx = IOBUS_OUT[0];
      if (IOBUS_OUT[1]) w_ovf_nx = 1'b0;
    end
    // Overflow in the same cycle as a clear leaves OVF set.
    if (w_ovf_set) w_ovf_nx = 1'b1;
  end

  // State registers; sv_q resets high so a level already asserted does not push.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ie     <= 1'b1;
      r_intr   <= 1'b0;
      r_sv_q   <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nx;
      r_rd_ptr <= w_rd_ptr_nx;
      r_count  <= w_count_nx;
      r_ovf    <= w_ovf_nx;
      r_ie     <= w_ie_nx;
      r_intr   <= r_ie & ~w_empty;
      r_sv_q   <= SCAN_VALID;
    end
  end

  // Storage, not reset.
  always_ff @(posedge CLK) begin
    if (w_push && !w_flush) r_mem[r_wr_ptr] <= SCANCODE;
  end

  // IOBUS read mux.
  always_comb begin
    IOBUS_IN = 32'h0;
    if (IOBUS_ADDR == DATA_AD) begin
      if (!w_empty) IOBUS_IN = {24'h0, w_head};
    end else if (IOBUS_ADDR == STAT_AD) begin
      IOBUS_IN = {16'h0, 8'(r_count), 4'h0, r_ie, r_ovf, w_full, w_empty};
    end
  end

  assign INTR = r_intr;

endmodule

// File: tb/tb_kbd_scancode_fifo.sv
// Directed self-checking bench for kbd_scancode_fifo (DEPTH = 16).
module tb_kbd_scancode_fifo;

  localparam logic [31:0] DATA_AD  = 32'h1100_0100;
  localparam logic [31:0] STAT_AD  = 32'h1100_0104;
  localparam logic [31:0] OTHER_AD = 32'h1100_0108;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        SCAN_VALID;
  logic [7:0]  SCANCODE;
  logic [31:0] IOBUS_ADDR;
  logic        IOBUS_RD;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_OUT;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int vectors = 0;
  int miscompares = 0;

  kbd_scancode_fifo #(.DEPTH(16), .DATA_AD(DATA_AD), .STAT_AD(STAT_AD)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SCAN_VALID(SCAN_VALID), .SCANCODE(SCANCODE),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_RD(IOBUS_RD), .IOBUS_WR(IOBUS_WR),
    .IOBUS_OUT(IOBUS_OUT), .IOBUS_IN(IOBUS_IN), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stat(input string tag, input logic [31:0] exp);
    IOBUS_ADDR = STAT_AD;
    #1;
    chk(tag, IOBUS_IN, exp);
  endtask

  task automatic chk_data(input string tag, input logic [31:0] exp);
    IOBUS_ADDR = DATA_AD;
    #1;
    chk(tag, IOBUS_IN, exp);
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    chk(tag, {31'h0, INTR}, {31'h0, exp});
  endtask

  task automatic push(input logic [7:0] code);
    SCANCODE   = code;
    SCAN_VALID = 1'b1;
    tick();
    SCAN_VALID = 1'b0;
    tick();
  endtask

  task automatic pop();
    IOBUS_ADDR = DATA_AD;
    IOBUS_RD   = 1'b1;
    tick();
    IOBUS_RD   = 1'b0;
  endtask

  task automatic wr_stat(input logic [31:0] val);
    IOBUS_ADDR = STAT_AD;
    IOBUS_OUT  = val;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_OUT  = 32'h0;
  endtask

  initial begin
    RESET_N    = 1'b0;
    SCAN_VALID = 1'b1;
    SCANCODE   = 8'h5A;
    IOBUS_ADDR = 32'h0;
    IOBUS_RD   = 1'b0;
    IOBUS_WR   = 1'b0;
    IOBUS_OUT  = 32'h0;

    // 1: reset with SCAN_VALID held high through release
    tick(); tick();
    RESET_N = 1'b1;
    tick(); tick();
    chk_stat("reset_stat", 32'h0000_0009);
    chk_intr("reset_intr", 1'b0);
    SCAN_VALID = 1'b0;
    tick();
    chk_stat("reset_still_empty", 32'h0000_0009);

    // 2: single push, interrupt one cycle later, pop
    SCANCODE   = 8'h1C;
    SCAN_VALID = 1'b1;
    tick();
    chk_stat("push1_stat", 32'h0000_0108);
    chk_data("push1_data", 32'h0000_001C);
    chk_intr("push1_intr_same", 1'b0);
    SCAN_VALID = 1'b0;
    tick();
    chk_intr("push1_intr_next", 1'b1);
    IOBUS_ADDR = OTHER_AD;
    IOBUS_RD   = 1'b1;
    tick();
    IOBUS_RD   = 1'b0;
    chk("other_addr_read", IOBUS_IN, 32'h0);
    chk_stat("other_rd_no_pop", 32'h0000_0108);
    pop();
    chk_stat("pop1_stat", 32'h0000_0009);
    chk_data("pop1_data_empty", 32'h0);
    chk_intr("pop1_intr_same", 1'b1);
    tick();
    chk_intr("pop1_intr_next", 1'b0);
    pop();
    chk_stat("pop_empty_ignored", 32'h0000_0009);

    // 3: 17 pushes into 16 entries
    for (int i = 1; i <= 17; i++) push(8'(i));
    chk_stat("full_ovf_stat", 32'h0000_100E);
    chk_intr("full_intr", 1'b1);
    for (int i = 1; i <= 16; i++) begin
      chk_data($sformatf("drain_%0d", i), 32'(i));
      pop();
    end
    chk_data("drain_empty_data", 32'h0);
    chk_stat("drain_ovf_sticky", 32'h0000_000D);
    wr_stat(32'h0000_0003);
    chk_stat("ovf_cleared", 32'h0000_0009);

    // 4: full FIFO, push and pop together
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    chk_stat("refill_full", 32'h0000_100A);
    SCANCODE   = 8'hAA;
    SCAN_VALID = 1'b1;
    IOBUS_ADDR = DATA_AD;
    IOBUS_RD   = 1'b1;
    tick();
    SCAN_VALID = 1'b0;
    IOBUS_RD   = 1'b0;
    chk_stat("full_pushpop_stat", 32'h0000_100A);
    tick();
    for (int i = 1; i < 16; i++) begin
      chk_data($sformatf("wrap_%0d", i), 32'h20 + 32'(i));
      pop();
    end
    chk_data("wrap_last_AA", 32'h0000_00AA);
    pop();
    chk_stat("wrap_empty", 32'h0000_0009);
    tick();

    // 5: clear OVF + flush + IE=0 in the same cycle as a push
    push(8'h55);
    push(8'h66);
    chk_stat("pre_flush", 32'h0000_0208);
    SCANCODE   = 8'h77;
    SCAN_VALID = 1'b1;
    wr_stat(32'h0000_0006);
    SCAN_VALID = 1'b0;
    chk_stat("flush_stat", 32'h0000_0001);
    chk_data("flush_data", 32'h0);
    tick();
    chk_intr("flush_intr_low", 1'b0);
    push(8'h88);
    tick();
    chk_stat("ie0_push_stat", 32'h0000_0100);
    chk_intr("ie0_push_intr", 1'b0);
    chk_data("ie0_push_data", 32'h0000_0088);

    // 6: long SCAN_VALID level pushes once; reset discards queued codes
    SCANCODE   = 8'h99;
    SCAN_VALID = 1'b1;
    repeat (10) tick();
    SCAN_VALID = 1'b0;
    tick();
    chk_stat("hold_one_push", 32'h0000_0200);
    push(8'h3A);
    push(8'h3B);
    push(8'h3C);
    chk_stat("five_queued", 32'h0000_0500);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk_stat("midreset_stat", 32'h0000_0009);
    chk_data("midreset_data", 32'h0);
    chk_intr("midreset_intr", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
